datapath_xyz: RTL and testbench

Register-and-ALU datapath directly downstream of the CPU control state machine. It holds the three working registers X, Y and Z, plus the ULA (ALU). Each clock it applies the per-register operation codes (`tx`, `ty`, `tz`) and the ALU operation code (`tula`) issued by the control FSM. The net effect is that X loads external data, Y loads from X and can shift, and Z captures the ALU result of X and Y.

---
 rtl/datapath_xyz.sv | 145 ++++++++++++++
 tb/tb_datapath_xyz.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/datapath_xyz.sv
// X/Y/Z working registers plus ALU, driven each cycle by the control FSM op codes.
// Optional registered Z/N/C flags are compiled in with `DATAPATH_FLAGS_EN.

package datapath_xyz_pkg;
  typedef enum logic [3:0] {
    OP_CLEAR  = 4'd0,
    OP_LOAD   = 4'd1,
    OP_HOLD   = 4'd2,
    OP_SHIFTR = 4'd3
  } reg_op_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOT   = 4'd5,
    ALU_PASSX = 4'd6,
    ALU_PASSY = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } flags_t;
endpackage

// One working register; every op code outside 0..3 holds.
module datapath_xyz_reg
  import datapath_xyz_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] ld,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clock) begin
    if (reset) q <= '0;
    else begin
      case (op)
        OP_CLEAR:  q <= '0;
        OP_LOAD:   q <= ld;
        OP_SHIFTR: q <= {1'b0, q[WIDTH-1:1]};
        default:   q <= q;
      endcase
    end
  end
endmodule

module datapath_xyz
  import datapath_xyz_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       tx,
  input  logic [3:0]       ty,
  input  logic [3:0]       tz,
  input  logic [3:0]       tula,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] ula_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c
);
  localparam int NREG = 3;

  logic [NREG-1:0][3:0]       op;
  logic [NREG-1:0][WIDTH-1:0] src;
  logic [NREG-1:0][WIDTH-1:0] q;
  logic [WIDTH-1:0]           ula_res;
  flags_t                     flags;

  // Slot 0 = X, 1 = Y, 2 = Z; all load sources are pre-edge values.
  assign op  = {tz, ty, tx};
  assign src = {ula_res, q[0], din};

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    datapath_xyz_reg #(.WIDTH(WIDTH)) u_reg (
      .clock (clock),
      .reset (reset),
      .op    (op[g]),
      .ld    (src[g]),
      .q     (q[g])
    );
  end

  assign x = q[0];
  assign y = q[1];
  assign z = q[2];

  always_comb begin
    ula_res = '0;
    case (tula)
      ALU_ADD:   ula_res = x + y;
      ALU_SUB:   ula_res = x - y;
      ALU_AND:   ula_res = x & y;
      ALU_OR:    ula_res = x | y;
      ALU_XOR:   ula_res = x ^ y;
      ALU_NOT:   ula_res = ~x;
      ALU_PASSX: ula_res = x;
      ALU_PASSY: ula_res = y;
      default:   ula_res = '0;
    endcase
  end

  assign ula_out = ula_res;

`ifdef DATAPATH_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  logic           ula_c;

  always_comb begin
    sum_ext = {1'b0, x} + {1'b0, y};
    ula_c   = 1'b0;
    if (tula == ALU_ADD)      ula_c = sum_ext[WIDTH];
    else if (tula == ALU_SUB) ula_c = (x < y);
  end

  // Flags track only values actually loaded into Z.
  always_ff @(posedge clock) begin
    if (reset) flags <= '0;
    else if (tz == OP_LOAD) begin
      flags.z <= (ula_res == '0);
      flags.n <= ula_res[WIDTH-1];
      flags.c <= ula_c;
    end
  end
`else
  assign flags = '0;
`endif

  assign flag_z = flags.z;
  assign flag_n = flags.n;
  assign flag_c = flags.c;
endmodule

// File: tb/tb_datapath_xyz.sv
// Scoreboard bench for datapath_xyz: driver pushes model predictions, monitor pops and compares.
module tb_datapath_xyz;
  localparam int W = 8;
  localparam int M = 1 << W;
`ifdef DATAPATH_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic [3:0]   tx, ty, tz, tula;
  logic [W-1:0] x, y, z, ula_out;
  logic         flag_z, flag_n, flag_c;

  datapath_xyz #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .din(din), .tx(tx), .ty(ty), .tz(tz), .tula(tula),
    .x(x), .y(y), .z(z), .ula_out(ula_out),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] ula, x, y, z;
    logic         fz, fn, fc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   mx = 0, my = 0, mz = 0;
  bit   mfz = 0, mfn = 0, mfc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  task automatic alu_model(input int a, input int b, input int op, output int r, output bit c);
    c = 1'b0;
    case (op)
      0: begin r = (a + b) % M; c = (a + b) >= M; end
      1: begin r = (a - b + M) % M; c = a < b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (M - 1) - a;
      6: r = a;
      7: r = b;
      default: r = 0;
    endcase
  endtask

  function automatic int reg_next(input int cur, input int op, input int ld);
    case (op)
      0:       return 0;
      1:       return ld;
      3:       return cur / 2;
      default: return cur;
    endcase
  endfunction

  // Drive one command at a falling edge, predict, and wait for the next falling edge.
  task automatic step(input bit r, input int d, input int a, input int b, input int c, input int op);
    int   res, nx, ny, nz;
    bit   car;
    exp_t e;
    reset = r; din = W'(d); tx = 4'(a); ty = 4'(b); tz = 4'(c); tula = 4'(op);
    alu_model(mx, my, op, res, car);
    e.ula = W'(res);
    if (r) begin
      mx = 0; my = 0; mz = 0; mfz = 0; mfn = 0; mfc = 0;
    end else begin
      nx = reg_next(mx, a, d);
      ny = reg_next(my, b, mx);
      nz = reg_next(mz, c, res);
      if (c == 1) begin
        mfz = (res == 0); mfn = (res >= M / 2); mfc = car;
      end
      mx = nx; my = ny; mz = nz;
    end
    e.x = W'(mx); e.y = W'(my); e.z = W'(mz);
    e.fz = mfz & FLAGS_ON; e.fn = mfn & FLAGS_ON; e.fc = mfc & FLAGS_ON;
    sbq.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: ALU checked before the edge, registers after it.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (sbq.size() > 0) begin
        mon_e = sbq[0];
        check("ula_out", ula_out, mon_e.ula);
        @(posedge clock);
        #1;
        mon_e = sbq.pop_front();
        check("x", x, mon_e.x);
        check("y", y, mon_e.y);
        check("z", z, mon_e.z);
        check("flag_z", flag_z, mon_e.fz);
        check("flag_n", flag_n, mon_e.fn);
        check("flag_c", flag_c, mon_e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; din = '0; tx = '0; ty = '0; tz = '0; tula = '0;
    @(negedge clock);

    step(1, 'hAA, 1, 1, 1, 0);
    step(1, 'hAA, 1, 1, 1, 0);
    check("rst_x", x, 0); check("rst_y", y, 0); check("rst_z", z, 0);
    check("rst_flags", {flag_z, flag_n, flag_c}, 0);

    step(0, 'h10, 1, 2, 2, 0); check("seq1_x", x, 'h10);
    step(0, 'h30, 1, 1, 2, 0); check("seq2_x", x, 'h30); check("seq2_y", y, 'h10);
    step(0, 0, 2, 1, 2, 0);    check("seq3_y", y, 'h30);
    step(0, 0, 2, 3, 2, 0);    check("seq4_y", y, 'h18);
    step(0, 0, 2, 2, 1, 0);    check("seq5_z", z, 'h48);
    check("seq5_flags", {flag_z, flag_n, flag_c}, 0);

    step(0, 'h5A, 1, 2, 2, 0);
    step(0, 0, 2, 2, 2, 0);    check("hold_x", x, 'h5A);
    step(0, 0, 9, 2, 2, 0);    check("illegal_x", x, 'h5A);
    step(0, 0, 2, 2, 3, 0);    check("shr_z", z, 'h24);
    check("shr_flags", {flag_z, flag_n, flag_c}, 0);

    step(0, 9, 1, 2, 2, 0);
    step(0, 5, 1, 1, 2, 0);
    step(0, 0, 2, 2, 1, 1);    check("sub_z", z, 'hFC);
    check("sub_c", flag_c, FLAGS_ON); check("sub_n", flag_n, FLAGS_ON); check("sub_zf", flag_z, 0);

    step(0, 1, 1, 2, 2, 0);
    step(0, 'hFF, 1, 1, 2, 0);
    step(0, 0, 2, 2, 1, 0);    check("add_z", z, 0);
    check("add_c", flag_c, FLAGS_ON); check("add_zf", flag_z, FLAGS_ON);
    step(0, 0, 2, 2, 3, 0);    check("shr0_z", z, 0);
    check("shr0_flags_kept", {flag_z, flag_c}, {FLAGS_ON, FLAGS_ON});

    step(1, 0, 2, 2, 1, 4);    check("midrst_z", z, 0);
    check("midrst_flags", {flag_z, flag_n, flag_c}, 0);
    step(0, 7, 1, 2, 2, 0);    check("postrst_x", x, 'h07);

    step(0, 'hFF, 1, 2, 2, 0);
    step(0, 0, 3, 2, 2, 0);    check("shr_ones_x", x, 'h7F);

    repeat (400) begin
      int a, b, c;
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      c = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      step($urandom_range(0, 31) == 0, $urandom_range(0, M - 1), a, b, c, $urandom_range(0, 15));
    end

    step(0, 0, 2, 2, 2, 0);
    repeat (3) @(negedge clock);
    check("sbq_drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
